// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------------+
// | mips_pkg : shared widths and constants for the MIPS pipeline front end     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

    localparam int unsigned     PC_W_DEF     = 32;
    localparam int unsigned     INSTR_W_DEF  = 32;
    localparam logic [31:0]     NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0]     RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0]     PC_INC       = 32'h0000_0004;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage : mips_pkg

`default_nettype wire

// File: rtl/if_id_reg.sv
// +----------------------------------------------------------------------------+
// | if_id_reg : IF/ID pipeline register {pc4, instr, valid}, enable + sync clr |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_id_reg
    import mips_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [PC_W-1:0]    pc4_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [PC_W-1:0]    pc4_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    logic [PC_W-1:0]    pc4_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;

    // Clear outranks enable so a flush lands even while decode is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc4_q   <= '0;
            instr_q <= INSTR_W'(NOP_INSTR);
            valid_q <= 1'b0;
        end else if (clr_i) begin
            pc4_q   <= '0;
            instr_q <= INSTR_W'(NOP_INSTR);
            valid_q <= 1'b0;
        end else if (en_i) begin
            pc4_q   <= pc4_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule : if_id_reg

`default_nettype wire

// File: rtl/fetch_stage.sv
// +----------------------------------------------------------------------------+
// | fetch_stage : PC register, next-PC select and IF/ID for the 5-stage MIPS   |
// | Optional perf counters: define FETCH_PERF_CNT_EN.          Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned      PC_W     = PC_W_DEF,
    parameter int unsigned      INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pcwrite,
    input  logic               if_id_write,
    input  logic               jump,
    input  logic [PC_W-1:0]    jump_target,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    if_id_pc4,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic               misalign_err,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_count
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] redir_tgt;
    logic            redirect;
    logic            misalign_q, misalign_d;

    assign pc_plus4  = pc_q + PC_W'(PC_INC);
    assign redirect  = branch_taken | jump;
    // Branch resolves in EX, which is older than the jump in ID, so it wins.
    assign redir_tgt = branch_taken ? branch_target : jump_target;

    always_comb begin
        pc_d = pc_q;
        if (redirect)
            pc_d = {redir_tgt[PC_W-1:2], 2'b00};
        else if (pcwrite)
            pc_d = pc_plus4;
    end

    assign misalign_d = misalign_q | (redirect & is_misaligned(redir_tgt[1:0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .en_i    (if_id_write),
        .clr_i   (redirect),
        .pc4_i   (pc_plus4),
        .instr_i (imem_rdata),
        .pc4_o   (if_id_pc4),
        .instr_o (if_id_instr),
        .valid_o (if_id_valid)
    );

    assign imem_addr    = pc_q;
    assign misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pcwrite && !redirect && stall_q != 32'hFFFF_FFFF)
            stall_d = stall_q + 32'd1;
        if (redirect && flush_q != 32'hFFFF_FFFF)
            flush_d = flush_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule : fetch_stage

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +----------------------------------------------------------------------------+
// | tb_fetch_stage : directed self-checking bench for fetch_stage              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif
    localparam logic [31:0] c_TAG = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcwrite, if_id_write, jump, branch_taken;
    logic [31:0] jump_target, branch_target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_pc4, if_id_instr;
    logic        if_id_valid, misalign_err;
    logic [31:0] stall_cycles, flush_count;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Instruction memory returns a word tagged with its own address.
    assign imem_rdata = imem_addr ^ c_TAG;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pcwrite       (pcwrite),
        .if_id_write   (if_id_write),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_pc4     (if_id_pc4),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .misalign_err  (misalign_err),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] addr,
                              input logic [31:0] pc4, input logic [31:0] instr,
                              input logic valid);
        check({tag, ".addr"},  imem_addr,   addr);
        check({tag, ".pc4"},   if_id_pc4,   pc4);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    task automatic check_reset(input string tag);
        check_ifid(tag, 32'h0, 32'h0, 32'h0, 1'b0);
        check({tag, ".mis"},   {31'd0, misalign_err}, 32'd0);
        check({tag, ".stall"}, stall_cycles, 32'd0);
        check({tag, ".flush"}, flush_count,  32'd0);
    endtask

    initial begin
        rst = 1'b1; pcwrite = 1'b1; if_id_write = 1'b1;
        jump = 1'b0; branch_taken = 1'b0;
        jump_target = '0; branch_target = '0;

        #2;
        check_reset("rst0");
        #10;                                 // t=12, between edges
        rst = 1'b0;

        // Free run
        step(); check_ifid("run4",  32'h04, 32'h04, c_TAG ^ 32'h00, 1'b1);
        step(); check_ifid("run8",  32'h08, 32'h08, c_TAG ^ 32'h04, 1'b1);
        step(); check_ifid("runC",  32'h0C, 32'h0C, c_TAG ^ 32'h08, 1'b1);
        step(); check_ifid("run10", 32'h10, 32'h10, c_TAG ^ 32'h0C, 1'b1);

        // Full stall for two cycles at PC=0x10
        pcwrite = 1'b0; if_id_write = 1'b0;
        step(); check_ifid("stl1", 32'h10, 32'h10, c_TAG ^ 32'h0C, 1'b1);
        step(); check_ifid("stl2", 32'h10, 32'h10, c_TAG ^ 32'h0C, 1'b1);
        check("stl.cnt", stall_cycles, c_PERF ? 32'd2 : 32'd0);
        pcwrite = 1'b1; if_id_write = 1'b1;
        step(); check_ifid("res14", 32'h14, 32'h14, c_TAG ^ 32'h10, 1'b1);
        step(); step(); step();
        check("at20", imem_addr, 32'h20);

        // Jump from 0x20 to 0x100
        jump = 1'b1; jump_target = 32'h100;
        step(); check_ifid("jmp", 32'h100, 32'h0, 32'h0, 1'b0);
        jump = 1'b0;
        step(); check_ifid("jmp+1", 32'h104, 32'h104, c_TAG ^ 32'h100, 1'b1);
        check("jmp.flush", flush_count, c_PERF ? 32'd1 : 32'd0);

        // pcwrite=0 with if_id_write=1 reloads the same entry
        pcwrite = 1'b0;
        step(); check_ifid("idem1", 32'h104, 32'h108, c_TAG ^ 32'h104, 1'b1);
        step(); check_ifid("idem2", 32'h104, 32'h108, c_TAG ^ 32'h104, 1'b1);

        // Branch + jump + stall together: branch wins, one flush
        branch_taken = 1'b1; branch_target = 32'h200;
        jump = 1'b1; jump_target = 32'h300;
        step(); check_ifid("bj", 32'h200, 32'h0, 32'h0, 1'b0);
        check("bj.flush", flush_count,  c_PERF ? 32'd2 : 32'd0);
        check("bj.stall", stall_cycles, c_PERF ? 32'd4 : 32'd0);
        branch_taken = 1'b0; jump = 1'b0; pcwrite = 1'b1;
        step(); check_ifid("bj+1", 32'h204, 32'h204, c_TAG ^ 32'h200, 1'b1);

        // PC wrap at the top of the address space
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step(); check("wrap.top", imem_addr, 32'hFFFF_FFFC);
        jump = 1'b0;
        step(); check_ifid("wrap", 32'h0, 32'h0, c_TAG ^ 32'hFFFF_FFFC, 1'b1);
        check("wrap.mis", {31'd0, misalign_err}, 32'd0);

        // Misaligned branch target: low bits dropped, sticky error
        branch_taken = 1'b1; branch_target = 32'h202;
        step(); check("mis.addr", imem_addr, 32'h200);
        check("mis.set", {31'd0, misalign_err}, 32'd1);
        branch_taken = 1'b0;
        step(); step();
        check("mis.hold", {31'd0, misalign_err}, 32'd1);
        check("mis.run", imem_addr, 32'h208);
        check("mis.flush", flush_count, c_PERF ? 32'd4 : 32'd0);

        // Asynchronous reset in the middle of a stall, no clock edge
        pcwrite = 1'b0; if_id_write = 1'b0;
        step();
        #2 rst = 1'b1;
        #1 check_reset("arst");
        @(negedge clk);
        rst = 1'b0; pcwrite = 1'b1; if_id_write = 1'b1;
        step(); check_ifid("post", 32'h04, 32'h04, c_TAG ^ 32'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_fetch_stage

`default_nettype wire
